// File: rtl/spi_master_shifter.sv
// SPI master shift engine: frames one DATA_W-bit transfer (SS_n, MOSI, MISO) against an external SCLK generator.
// Bit order is MSB first by default; defining SPI_LSB_FIRST_EN switches TX and RX to LSB first.
module spi_master_shifter #(
  parameter logic [1:0] MODE      = 2'b11,
  parameter int         DATA_W    = 8,
  parameter int         SETUP_CYC = 4,
  parameter int         HOLD_CYC  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk_start,
  input  logic              sclk,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic CPOL  = MODE[1];
  localparam logic CPHA  = MODE[0];
  localparam int   CNT_W = $clog2(DATA_W + 1);

  localparam logic [7:0]       SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0]       HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        cyc_cnt;
  logic              sclk_d;
  logic              seen_lead;

  logic              sclk_chg;
  logic              lead_edge;
  logic              trail_edge;

  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_shifted;
  logic              tx_cur_bit;
  logic              tx_next_bit;
  logic              data_first;

  assign sclk_chg   = (sclk != sclk_d);
  assign lead_edge  = sclk_chg && (sclk != CPOL);
  assign trail_edge = sclk_chg && (sclk == CPOL);

  always_comb begin
    tx_shifted  = '0;
    rx_shifted  = '0;
    tx_cur_bit  = 1'b0;
    tx_next_bit = 1'b0;
    data_first  = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    tx_shifted  = {1'b0, tx_sr[DATA_W-1:1]};
    rx_shifted  = {MISO, rx_sr[DATA_W-1:1]};
    tx_cur_bit  = tx_sr[0];
    tx_next_bit = tx_sr[1];
    data_first  = tx_data[0];
`else
    tx_shifted  = {tx_sr[DATA_W-2:0], 1'b0};
    rx_shifted  = {rx_sr[DATA_W-2:0], MISO};
    tx_cur_bit  = tx_sr[DATA_W-1];
    tx_next_bit = tx_sr[DATA_W-2];
    data_first  = tx_data[DATA_W-1];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      SS_n       <= 1'b1;
      sclk_start <= 1'b0;
      MOSI       <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
      sclk_d     <= CPOL;
      seen_lead  <= 1'b0;
    end else begin
      sclk_d   <= sclk;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_sr     <= tx_data;
            SS_n      <= 1'b0;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            seen_lead <= 1'b0;
            busy      <= 1'b1;
            tx_ready  <= 1'b0;
            if (CPHA == 1'b0) begin
              MOSI <= data_first;
            end
            state <= SETUP;
          end
        end

        SETUP: begin
          if (cyc_cnt == SETUP_LAST) begin
            cyc_cnt    <= '0;
            sclk_start <= 1'b1;
            state      <= XFER;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end

        XFER: begin
          if (lead_edge) begin
            seen_lead <= 1'b1;
            if (CPHA == 1'b0) begin
              rx_sr <= rx_shifted;
            end else begin
              MOSI  <= tx_cur_bit;
              tx_sr <= tx_shifted;
            end
          // A trailing edge before the first leading edge belongs to no bit.
          end else if (trail_edge && seen_lead) begin
            if (CPHA == 1'b0) begin
              tx_sr <= tx_shifted;
              if (bit_cnt != BIT_LAST) begin
                MOSI <= tx_next_bit;
              end
            end else begin
              rx_sr <= rx_shifted;
            end
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              sclk_start <= 1'b0;
              cyc_cnt    <= '0;
              state      <= HOLD;
            end
          end
        end

        HOLD: begin
          if (cyc_cnt == HOLD_LAST) begin
            cyc_cnt  <= '0;
            SS_n     <= 1'b1;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            state    <= DONE;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end

        DONE: begin
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          SS_n       <= 1'b1;
          sclk_start <= 1'b0;
          busy       <= 1'b0;
          tx_ready   <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
